// File: rtl/scan_test_ctrl.sv
// ---------------------------------------------------------------------------
// scan_test_ctrl
//   Sequencer for a single scan chain. A start request loads a pattern
//   through SI with TM high, drops TM for a functional capture window, then
//   shifts the chain back out through SO. The unloaded contents are compared
//   against an expected vector under a care mask, and the result is reported.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start, abort        run request (ignored while busy), test termination
//   pattern_in          load vector, bit i lands at chain position i
//   expect_in, mask_in  expected unload vector and care mask (1 = compare)
//   tm, si, so          DUT test-mode select, scan input, scan output
//   busy, done          test in progress, one-cycle completion pulse
//   pass, fail_count    result of last completed test, mismatching care bits
//   captured            unloaded chain contents, indexed by chain position
// ---------------------------------------------------------------------------
module scan_test_ctrl #(
  parameter int CHAIN_LEN      = 25,
  parameter int CAPTURE_CYCLES = 1,
  parameter int SO_LAT         = 1,
  parameter int CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] pattern_in,
  input  logic [CHAIN_LEN-1:0] expect_in,
  input  logic [CHAIN_LEN-1:0] mask_in,
  output logic                 tm,
  output logic                 si,
  input  logic                 so,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     fail_count,
  output logic [CHAIN_LEN-1:0] captured
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_UNLOAD  = 3'd3;
  localparam logic [2:0] S_COMPARE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam int UNL_LEN = CHAIN_LEN + SO_LAT;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CAP_LAST  = CNT_W'(CAPTURE_CYCLES - 1);
  localparam logic [CNT_W-1:0] UNL_LAST  = CNT_W'(UNL_LEN - 1);

  // Parameter sanity: the counter must never wrap inside a phase.
  if (CHAIN_LEN < 2) begin : g_bad_chain_len
    $error("scan_test_ctrl: CHAIN_LEN must be at least 2");
  end
  if (CAPTURE_CYCLES < 1) begin : g_bad_capture
    $error("scan_test_ctrl: CAPTURE_CYCLES must be at least 1");
  end
  if (SO_LAT < 0 || SO_LAT > 3) begin : g_bad_so_lat
    $error("scan_test_ctrl: SO_LAT must be in 0..3");
  end
  if (UNL_LEN > CNT_MAX || CAPTURE_CYCLES > CNT_MAX) begin : g_bad_cnt_w
    $error("scan_test_ctrl: CNT_W too narrow for CHAIN_LEN+SO_LAT or CAPTURE_CYCLES");
  end

  // Population count of the mismatch vector, saturated to the counter width.
  function automatic logic [CNT_W-1:0] sat_popcount(input logic [CHAIN_LEN-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < CHAIN_LEN; i++) begin
      if (v[i]) n++;
    end
    if (n > CNT_MAX) return '1;
    return CNT_W'(n);
  endfunction

  logic [2:0]           state;
  logic [CNT_W-1:0]     cnt;
  // Pattern bits still to be shifted; bit CHAIN_LEN-1 goes out on the start edge.
  logic [CHAIN_LEN-2:0] pat_sh;
  logic [CHAIN_LEN-1:0] exp_sh;
  logic [CHAIN_LEN-1:0] mask_sh;
  // Unload shadow is SO_LAT bits wider than the chain: the flush samples
  // taken while the SO pipeline drains end up in the top bits and are dropped.
  logic [UNL_LEN-1:0]   cap_sh;
  logic [CHAIN_LEN-1:0] miscmp;

  assign miscmp = (cap_sh[CHAIN_LEN-1:0] ^ exp_sh) & mask_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      pat_sh     <= '0;
      exp_sh     <= '0;
      mask_sh    <= '0;
      cap_sh     <= '0;
      tm         <= 1'b0;
      si         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_count <= '0;
      captured   <= '0;
    end else begin
      done <= 1'b0;
      if (state != S_IDLE && abort) begin
        // Abort leaves pass/fail_count/captured untouched: results are only
        // published on the COMPARE edge.
        state <= S_IDLE;
        cnt   <= '0;
        tm    <= 1'b0;
        si    <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            tm <= 1'b0;
            si <= 1'b0;
            if (start && !abort) begin
              pat_sh  <= pattern_in[CHAIN_LEN-2:0];
              exp_sh  <= expect_in;
              mask_sh <= mask_in;
              cap_sh  <= '0;
              cnt     <= '0;
              state   <= S_LOAD;
              tm      <= 1'b1;
              si      <= pattern_in[CHAIN_LEN-1];
              busy    <= 1'b1;
            end
          end

          // ---- load: shift pattern MSB-first into the chain ----
          S_LOAD: begin
            pat_sh <= pat_sh << 1;
            if (cnt == LOAD_LAST) begin
              state <= S_CAPTURE;
              cnt   <= '0;
              tm    <= 1'b0;
              si    <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
              si  <= pat_sh[CHAIN_LEN-2];
            end
          end

          // ---- capture: functional window with tm low ----
          S_CAPTURE: begin
            if (cnt == CAP_LAST) begin
              state <= S_UNLOAD;
              cnt   <= '0;
              tm    <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          // ---- unload: chain tail first, lands at the top of the shadow ----
          S_UNLOAD: begin
            cap_sh <= (cap_sh << 1) | UNL_LEN'(so);
            if (cnt == UNL_LAST) begin
              state <= S_COMPARE;
              cnt   <= '0;
              tm    <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          // ---- compare: publish results ----
          S_COMPARE: begin
            captured   <= cap_sh[CHAIN_LEN-1:0];
            fail_count <= sat_popcount(miscmp);
            pass       <= (miscmp == '0);
            done       <= 1'b1;
            state      <= S_DONE;
          end

          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end

          default: begin
            state <= S_IDLE;
            cnt   <= '0;
            tm    <= 1'b0;
            si    <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scan_test_ctrl.sv
// ---------------------------------------------------------------------------
// tb_scan_test_ctrl
//   Bench for scan_test_ctrl with a behavioural scan chain (tm-gated shift
//   register plus one registered SO stage, capture leaves the chain as is).
//   Expected results are pushed to a queue when a test is launched and popped
//   when the controller signals done.
// ---------------------------------------------------------------------------
module tb_scan_test_ctrl;

  localparam int CL = 25;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CL-1:0] pattern_in = '0;
  logic [CL-1:0] expect_in = '0;
  logic [CL-1:0] mask_in = '0;
  logic          tm, si, so, busy, done, pass;
  logic [CW-1:0] fail_count;
  logic [CL-1:0] captured;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  scan_test_ctrl #(
    .CHAIN_LEN(CL), .CAPTURE_CYCLES(1), .SO_LAT(1), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pattern_in(pattern_in), .expect_in(expect_in), .mask_in(mask_in),
    .tm(tm), .si(si), .so(so), .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .captured(captured)
  );

  // Scan chain of the device under test.
  logic [CL-1:0] chain = '0;
  logic          so_q = 1'b0;
  logic          so_inv = 1'b0;
  always @(posedge clk) begin
    if (tm) chain <= {chain[CL-2:0], si};
    so_q <= chain[CL-1];
  end
  assign so = so_q ^ so_inv;

  typedef struct packed {
    logic          pass;
    logic [CW-1:0] fc;
    logic [CL-1:0] cap;
  } res_t;

  res_t sb[$];
  res_t last_res;

  function automatic res_t model(input logic [CL-1:0] pat, input logic [CL-1:0] exp_v,
                                 input logic [CL-1:0] msk, input logic inv);
    res_t r;
    logic [CL-1:0] diff;
    int n;
    r.cap = inv ? ~pat : pat;
    diff  = (r.cap ^ exp_v) & msk;
    n = 0;
    for (int i = 0; i < CL; i++) if (diff[i]) n++;
    r.fc   = (n > 255) ? 8'hFF : CW'(n);
    r.pass = (n == 0);
    return r;
  endfunction

  // Drives a one-cycle start; returns at the negedge after the start edge.
  task automatic launch(input logic [CL-1:0] pat, input logic [CL-1:0] exp_v,
                        input logic [CL-1:0] msk, input logic inv, input bit push);
    @(negedge clk);
    so_inv     = inv;
    pattern_in = pat;
    expect_in  = exp_v;
    mask_in    = msk;
    start      = 1'b1;
    if (push) sb.push_back(model(pat, exp_v, msk, inv));
    @(negedge clk);
    start      = 1'b0;
    pattern_in = ~pat;
    expect_in  = ~exp_v;
    mask_in    = ~msk;
  endtask

  // edges = number of clock edges since (and including) the start edge.
  task automatic wait_done(input int first, output int edges, output bit ok);
    edges = first;
    ok = 1'b0;
    while (edges < 300) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    vectors++; if (tm !== 1'b0) begin miscompares++; $display("FAIL reset_tm: got %b want 0", tm); end
    vectors++; if (si !== 1'b0) begin miscompares++; $display("FAIL reset_si: got %b want 0", si); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (pass !== 1'b0) begin miscompares++; $display("FAIL reset_pass: got %b want 0", pass); end
    vectors++; if (fail_count !== '0) begin miscompares++; $display("FAIL reset_fail_count: got %0d want 0", fail_count); end
    vectors++; if (captured !== '0) begin miscompares++; $display("FAIL reset_captured: got %h want 0", captured); end
    rst = 1'b0;
  endtask

  task automatic test_tm_waveform;
    logic [CL-1:0] pat;
    logic exp_tm, exp_si;
    res_t r;
    pat = 25'h1A5_5A5A;
    launch(pat, pat, '1, 1'b0, 1'b1);
    for (int j = 0; j < 54; j++) begin
      exp_tm = (j < 25) || (j >= 26 && j < 52);
      exp_si = (j < 25) ? pat[24-j] : 1'b0;
      vectors++; if (tm !== exp_tm) begin miscompares++; $display("FAIL wave_tm[%0d]: got %b want %b", j, tm, exp_tm); end
      vectors++; if (si !== exp_si) begin miscompares++; $display("FAIL wave_si[%0d]: got %b want %b", j, si, exp_si); end
      if (j < 53) @(negedge clk);
    end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL wave_done: got %b want 1", done); end
    if (sb.size() == 0) begin
      vectors++; miscompares++; $display("FAIL wave_sb: got empty queue want entry");
    end else begin
      r = sb.pop_front();
      vectors++; if (pass !== r.pass) begin miscompares++; $display("FAIL wave_pass: got %b want %b", pass, r.pass); end
      vectors++; if (captured !== r.cap) begin miscompares++; $display("FAIL wave_captured: got %h want %h", captured, r.cap); end
      last_res = r;
    end
    @(negedge clk);
  endtask

  task automatic test_loopback;
    logic [CL-1:0] p[4], e[4], m[4];
    logic inv[4];
    int edges;
    bit ok;
    res_t r;
    p[0] = 25'h1A5_5A5A; e[0] = 25'h1A5_5A5A;            m[0] = '1;          inv[0] = 1'b0;
    p[1] = 25'h0F0_F0F3; e[1] = 25'h0F0_F0F3;            m[1] = '0;          inv[1] = 1'b1;
    p[2] = 25'h1A5_5A5A; e[2] = 25'h1A5_5A5A ^ 25'h11;   m[2] = '1;          inv[2] = 1'b0;
    p[3] = 25'h1A5_5A5A; e[3] = 25'h1A5_5A5A ^ 25'h11;   m[3] = ~25'h1;      inv[3] = 1'b0;
    for (int t = 0; t < 4; t++) begin
      launch(p[t], e[t], m[t], inv[t], 1'b1);
      wait_done(1, edges, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL loop%0d_timeout: got no done want done", t); end
      vectors++; if (edges !== 54) begin miscompares++; $display("FAIL loop%0d_latency: got %0d want 54", t, edges); end
      if (sb.size() == 0) begin
        vectors++; miscompares++; $display("FAIL loop%0d_sb: got empty queue want entry", t);
      end else begin
        r = sb.pop_front();
        vectors++; if (pass !== r.pass) begin miscompares++; $display("FAIL loop%0d_pass: got %b want %b", t, pass, r.pass); end
        vectors++; if (fail_count !== r.fc) begin miscompares++; $display("FAIL loop%0d_fail_count: got %0d want %0d", t, fail_count, r.fc); end
        vectors++; if (captured !== r.cap) begin miscompares++; $display("FAIL loop%0d_captured: got %h want %h", t, captured, r.cap); end
        last_res = r;
      end
      @(negedge clk);
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL loop%0d_done_pulse: got %b want 0", t, done); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL loop%0d_busy_end: got %b want 0", t, busy); end
    end
    so_inv = 1'b0;
  endtask

  task automatic test_abort;
    res_t prev;
    int seen_done;
    prev = last_res;
    launch(25'h0AA_AAAA, 25'h0AA_AAAA, '1, 1'b0, 1'b0);
    // Now just after the start edge; move to just before unload edge 10.
    repeat (36) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vectors++; if (tm !== 1'b0) begin miscompares++; $display("FAIL abort_tm: got %b want 0", tm); end
    vectors++; if (si !== 1'b0) begin miscompares++; $display("FAIL abort_si: got %b want 0", si); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", busy); end
    seen_done = 0;
    repeat (40) begin
      if (done === 1'b1) seen_done++;
      @(negedge clk);
    end
    vectors++; if (seen_done !== 0) begin miscompares++; $display("FAIL abort_no_done: got %0d pulses want 0", seen_done); end
    vectors++; if (pass !== prev.pass) begin miscompares++; $display("FAIL abort_pass_hold: got %b want %b", pass, prev.pass); end
    vectors++; if (fail_count !== prev.fc) begin miscompares++; $display("FAIL abort_fc_hold: got %0d want %0d", fail_count, prev.fc); end
    vectors++; if (captured !== prev.cap) begin miscompares++; $display("FAIL abort_cap_hold: got %h want %h", captured, prev.cap); end
  endtask

  task automatic test_back_to_back;
    int edges, pulses;
    bit ok;
    res_t r;
    launch(25'h155_3C3C, 25'h155_3C3C, '1, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    start = 1'b1;
    pattern_in = 25'h000_0001;
    @(negedge clk);
    start = 1'b0;
    wait_done(7, edges, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL b2b_timeout: got no done want done"); end
    vectors++; if (edges !== 54) begin miscompares++; $display("FAIL b2b_latency: got %0d want 54", edges); end
    if (sb.size() == 0) begin
      vectors++; miscompares++; $display("FAIL b2b_sb: got empty queue want entry");
    end else begin
      r = sb.pop_front();
      vectors++; if (pass !== r.pass) begin miscompares++; $display("FAIL b2b_pass: got %b want %b", pass, r.pass); end
      vectors++; if (captured !== r.cap) begin miscompares++; $display("FAIL b2b_captured: got %h want %h", captured, r.cap); end
      last_res = r;
    end
    @(negedge clk);
    pulses = 0;
    repeat (70) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL b2b_extra_done: got %0d pulses want 0", pulses); end
  endtask

  task automatic test_start_abort_idle;
    int active;
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_abort_busy: got %b want 0", busy); end
    vectors++; if (tm !== 1'b0) begin miscompares++; $display("FAIL idle_abort_tm: got %b want 0", tm); end
    active = 0;
    repeat (60) begin
      if (busy === 1'b1 || done === 1'b1 || tm === 1'b1) active++;
      @(negedge clk);
    end
    vectors++; if (active !== 0) begin miscompares++; $display("FAIL idle_abort_quiet: got %0d active cycles want 0", active); end
  endtask

  task automatic test_reset_midtest;
    int edges;
    bit ok;
    res_t r;
    launch(25'h1C3_8E71, 25'h1C3_8E71, '1, 1'b0, 1'b0);
    repeat (25) @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++; if (tm !== 1'b0) begin miscompares++; $display("FAIL rst_mid_tm: got %b want 0", tm); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    vectors++; if (pass !== 1'b0) begin miscompares++; $display("FAIL rst_mid_pass: got %b want 0", pass); end
    vectors++; if (fail_count !== '0) begin miscompares++; $display("FAIL rst_mid_fc: got %0d want 0", fail_count); end
    vectors++; if (captured !== '0) begin miscompares++; $display("FAIL rst_mid_captured: got %h want 0", captured); end
    @(negedge clk);
    rst = 1'b0;
    launch(25'h0DE_AD5B, 25'h0DE_AD5B, '1, 1'b0, 1'b1);
    wait_done(1, edges, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rst_rerun_timeout: got no done want done"); end
    vectors++; if (edges !== 54) begin miscompares++; $display("FAIL rst_rerun_latency: got %0d want 54", edges); end
    if (sb.size() == 0) begin
      vectors++; miscompares++; $display("FAIL rst_rerun_sb: got empty queue want entry");
    end else begin
      r = sb.pop_front();
      vectors++; if (pass !== r.pass) begin miscompares++; $display("FAIL rst_rerun_pass: got %b want %b", pass, r.pass); end
      vectors++; if (fail_count !== r.fc) begin miscompares++; $display("FAIL rst_rerun_fc: got %0d want %0d", fail_count, r.fc); end
      vectors++; if (captured !== r.cap) begin miscompares++; $display("FAIL rst_rerun_captured: got %h want %h", captured, r.cap); end
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    test_reset();
    test_tm_waveform();
    test_loopback();
    test_abort();
    test_back_to_back();
    test_start_abort_idle();
    test_reset_midtest();
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++;
      $display("FAIL sb_drain: got %0d leftover entries want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
